bcd_entry_sequencer: RTL and testbench

BCD_ENTRY_SEQUENCER -- requirements
Module: bcd_entry_sequencer

---
 rtl/bcd_entry_sequencer.sv | 134 +++++++++++++
 tb/tb_bcd_entry_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_entry_sequencer.sv
// BCD keypad entry register with a serial BCD-to-binary converter.
// Digits shift in at the bottom, backspace shifts them back out, and enter
// converts the captured entry one digit per cycle, most significant first.
module bcd_entry_sequencer #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned BIN_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_digit,
    input  logic                  key_clear,
    input  logic                  key_back,
    input  logic                  key_enter,
    output logic [4*DIGITS-1:0]   bcd_disp,
    output logic [2:0]            digit_count,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  bin_valid,
    output logic                  busy
);

    localparam int unsigned DISP_W = 4 * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ENTRY = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state, state_n;
    logic [DISP_W-1:0] disp_n;
    logic [2:0]        count_n;
    logic [BIN_W-1:0]  bin_out_n;
    logic              bin_valid_n;
    logic              busy_n;
    logic [DISP_W-1:0] work, work_n;
    logic [BIN_W-1:0]  acc, acc_n;
    logic [IDX_W-1:0]  index, index_n;

    logic [3:0]        work_digit_c;
    logic [BIN_W-1:0]  acc_times10_c;

    // Current digit under conversion and the shift-add multiply by ten.
    assign work_digit_c  = work[4*int'(index) +: 4];
    assign acc_times10_c = (acc << 3) + (acc << 1);

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        disp_n      = bcd_disp;
        count_n     = digit_count;
        bin_out_n   = bin_out;
        bin_valid_n = 1'b0;
        work_n      = work;
        acc_n       = acc;
        index_n     = index;

        case (state)
            ENTRY: begin
                if (key_clear) begin
                    disp_n  = '0;
                    count_n = '0;
                end else if (key_back) begin
                    // Backspace wins over lower-priority keys even when empty.
                    if (digit_count != 3'd0) begin
                        disp_n  = bcd_disp >> 4;
                        count_n = digit_count - 3'd1;
                    end
                end else if (key_enter) begin
                    work_n  = bcd_disp;
                    acc_n   = '0;
                    index_n = IDX_W'(DIGITS - 1);
                    state_n = CONV;
                end else if (key_valid && (key_digit <= 4'd9) &&
                             (digit_count < 3'(DIGITS)) &&
                             !((key_digit == 4'd0) && (digit_count == 3'd0))) begin
                    disp_n  = {bcd_disp[DISP_W-5:0], key_digit};
                    count_n = digit_count + 3'd1;
                end
            end
            CONV: begin
                if (key_clear) begin
                    disp_n  = '0;
                    count_n = '0;
                    state_n = ENTRY;
                end else begin
                    acc_n = acc_times10_c + BIN_W'(work_digit_c);
                    if (index == '0) begin
                        bin_out_n   = acc_n;
                        bin_valid_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        index_n = index - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                disp_n  = '0;
                count_n = '0;
                state_n = ENTRY;
            end
            default: begin
                state_n = ENTRY;
            end
        endcase

        busy_n = (state_n == CONV);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ENTRY;
            bcd_disp    <= '0;
            digit_count <= '0;
            bin_out     <= '0;
            bin_valid   <= 1'b0;
            busy        <= 1'b0;
            work        <= '0;
            acc         <= '0;
            index       <= '0;
        end else begin
            state       <= state_n;
            bcd_disp    <= disp_n;
            digit_count <= count_n;
            bin_out     <= bin_out_n;
            bin_valid   <= bin_valid_n;
            busy        <= busy_n;
            work        <= work_n;
            acc         <= acc_n;
            index       <= index_n;
        end
    end

endmodule

// File: tb/tb_bcd_entry_sequencer.sv
// Self-checking bench for bcd_entry_sequencer: vector table, directed
// corner sequences and a randomized run against a digit-list model.
module tb_bcd_entry_sequencer;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned BIN_W  = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic                key_valid;
    logic [3:0]          key_digit;
    logic                key_clear;
    logic                key_back;
    logic                key_enter;
    logic [4*DIGITS-1:0] bcd_disp;
    logic [2:0]          digit_count;
    logic [BIN_W-1:0]    bin_out;
    logic                bin_valid;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    bcd_entry_sequencer #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_digit(key_digit),
        .key_clear(key_clear), .key_back(key_back), .key_enter(key_enter),
        .bcd_disp(bcd_disp), .digit_count(digit_count),
        .bin_out(bin_out), .bin_valid(bin_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         clr;
        bit         back;
        bit         ent;
        bit         vld;
        logic [3:0] dig;
        logic [23:0] exp_disp;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[17];

    // Reference model: entered digits, most significant first.
    int digs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_keys();
        key_valid = 1'b0; key_digit = 4'd0; key_clear = 1'b0;
        key_back = 1'b0; key_enter = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_keys();
        rst = 1'b1;
        step();
        rst = 1'b0;
        digs.delete();
    endtask

    function automatic logic [23:0] model_disp();
        logic [23:0] d = '0;
        foreach (digs[i]) d = {d[19:0], 4'(digs[i])};
        return d;
    endfunction

    function automatic logic [23:0] model_value();
        int v = 0;
        foreach (digs[i]) v = v * 10 + digs[i];
        return 24'(v);
    endfunction

    task automatic key(input int d);
        idle_keys();
        key_valid = 1'b1; key_digit = 4'(d);
        step();
        idle_keys();
        if (d <= 9 && digs.size() < DIGITS && !(d == 0 && digs.size() == 0))
            digs.push_back(d);
    endtask

    // Press enter and follow the conversion through DONE, injecting ignored keys.
    task automatic do_conv(input string name, input bit noise);
        logic [23:0] exp_val  = model_value();
        logic [23:0] exp_disp = model_disp();
        idle_keys();
        key_enter = 1'b1;
        step();
        for (int c = 1; c <= DIGITS; c++) begin
            chk({name, " busy"}, 64'(busy), 64'd1);
            chk({name, " no early valid"}, 64'(bin_valid), 64'd0);
            chk({name, " disp stable"}, 64'(bcd_disp), 64'(exp_disp));
            idle_keys();
            if (noise) begin
                key_valid = 1'($urandom_range(0, 1));
                key_digit = 4'($urandom_range(0, 9));
                key_back  = 1'($urandom_range(0, 1));
                key_enter = 1'($urandom_range(0, 1));
            end
            step();
        end
        chk({name, " busy low at done"}, 64'(busy), 64'd0);
        chk({name, " valid pulse"}, 64'(bin_valid), 64'd1);
        chk({name, " bin_out"}, 64'(bin_out), 64'(exp_val));
        idle_keys();
        if (noise) key_clear = 1'($urandom_range(0, 1));
        step();
        idle_keys();
        chk({name, " single pulse"}, 64'(bin_valid), 64'd0);
        chk({name, " count cleared"}, 64'(digit_count), 64'd0);
        chk({name, " disp cleared"}, 64'(bcd_disp), 64'd0);
        chk({name, " bin_out held"}, 64'(bin_out), 64'(exp_val));
        digs.delete();
    endtask

    initial begin
        logic [23:0] prev;

        vecs[0]  = '{0,0,0,1,4'd0, 24'h000000, 0};
        vecs[1]  = '{0,0,0,1,4'd0, 24'h000000, 0};
        vecs[2]  = '{0,0,0,1,4'd7, 24'h000007, 1};
        vecs[3]  = '{0,0,0,1,4'd0, 24'h000070, 2};
        vecs[4]  = '{0,0,0,1,4'hA, 24'h000070, 2};
        vecs[5]  = '{0,1,0,0,4'd0, 24'h000007, 1};
        vecs[6]  = '{1,0,0,1,4'd5, 24'h000000, 0};
        vecs[7]  = '{0,1,0,0,4'd0, 24'h000000, 0};
        vecs[8]  = '{0,0,0,1,4'd1, 24'h000001, 1};
        vecs[9]  = '{0,0,0,1,4'd2, 24'h000012, 2};
        vecs[10] = '{0,1,1,0,4'd0, 24'h000001, 1};
        vecs[11] = '{0,1,0,1,4'd9, 24'h000000, 0};
        vecs[12] = '{0,0,0,1,4'd9, 24'h000009, 1};
        vecs[13] = '{0,0,0,1,4'd8, 24'h000098, 2};
        vecs[14] = '{0,0,0,1,4'd7, 24'h000987, 3};
        vecs[15] = '{0,1,0,0,4'd0, 24'h000098, 2};
        vecs[16] = '{1,0,0,0,4'd3, 24'h000000, 0};

        idle_keys();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("reset disp", 64'(bcd_disp), 64'd0);
        chk("reset count", 64'(digit_count), 64'd0);
        chk("reset bin_out", 64'(bin_out), 64'd0);
        chk("reset valid", 64'(bin_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);

        // Single-cycle entry-state vectors.
        for (int i = 0; i < 17; i++) begin
            key_clear = vecs[i].clr; key_back = vecs[i].back;
            key_enter = vecs[i].ent; key_valid = vecs[i].vld;
            key_digit = vecs[i].dig;
            step();
            idle_keys();
            chk($sformatf("vec%0d disp", i), 64'(bcd_disp), 64'(vecs[i].exp_disp));
            chk($sformatf("vec%0d count", i), 64'(digit_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'd0);
            chk($sformatf("vec%0d valid", i), 64'(bin_valid), 64'd0);
        end
        digs.delete();

        // 1..6 then enter.
        for (int d = 1; d <= 6; d++) key(d);
        chk("123456 disp", 64'(bcd_disp), 64'h123456);
        do_conv("conv123456", 1'b0);

        // Leading zeros suppressed.
        key(0); key(0); key(7);
        chk("007 count", 64'(digit_count), 64'd1);
        chk("007 disp", 64'(bcd_disp), 64'h7);
        do_conv("conv7", 1'b0);

        // Full register, seventh digit ignored.
        repeat (7) key(9);
        chk("full count", 64'(digit_count), 64'd6);
        chk("full disp", 64'(bcd_disp), 64'h999999);
        do_conv("conv999999", 1'b0);

        // Abort with clear in the third conversion cycle.
        prev = bin_out;
        key(3); key(4); key(5);
        key_enter = 1'b1; step(); idle_keys();
        step();
        chk("abort busy c2", 64'(busy), 64'd1);
        step();
        key_clear = 1'b1; step(); idle_keys();
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort valid", 64'(bin_valid), 64'd0);
        chk("abort disp", 64'(bcd_disp), 64'd0);
        chk("abort count", 64'(digit_count), 64'd0);
        chk("abort bin_out kept", 64'(bin_out), 64'(prev));
        digs.delete();
        for (int c = 0; c < DIGITS + 2; c++) begin
            step();
            chk("abort no late valid", 64'(bin_valid), 64'd0);
        end
        key(10);
        chk("digit A ignored", 64'(digit_count), 64'd0);
        key(4);
        chk("entry after abort", 64'(bcd_disp), 64'h4);

        // Reset mid-conversion.
        key_enter = 1'b1; step(); idle_keys();
        step();
        do_reset();
        chk("rst conv disp", 64'(bcd_disp), 64'd0);
        chk("rst conv count", 64'(digit_count), 64'd0);
        chk("rst conv bin_out", 64'(bin_out), 64'd0);
        chk("rst conv valid", 64'(bin_valid), 64'd0);
        chk("rst conv busy", 64'(busy), 64'd0);
        for (int c = 0; c < DIGITS + 2; c++) begin
            step();
            chk("rst no valid", 64'(bin_valid), 64'd0);
        end

        // Prime bin_out, then enter on an empty register must yield 0.
        key(5);
        do_conv("conv5", 1'b0);
        do_conv("conv empty", 1'b0);

        // Randomized entry traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            int d = $urandom_range(0, 15);
            idle_keys();
            if (r < 4) begin
                key_clear = 1'b1;
                key_valid = 1'($urandom_range(0, 1)); key_digit = 4'(d);
                step();
                digs.delete();
            end else if (r < 16) begin
                key_back  = 1'b1;
                key_enter = 1'($urandom_range(0, 1));
                key_valid = 1'($urandom_range(0, 1)); key_digit = 4'(d);
                step();
                if (digs.size() > 0) void'(digs.pop_back());
            end else if (r < 22) begin
                do_conv("rand conv", 1'b1);
            end else begin
                key(d % 12);
            end
            idle_keys();
            chk("rand disp", 64'(bcd_disp), 64'(model_disp()));
            chk("rand count", 64'(digit_count), 64'(digs.size()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
